piso_serializer: RTL and testbench

Parallel-in, serial-out serializer that sits directly upstream of the serial-in/serial-out shift register stage. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto the single-bit serial line `d_out` one bit per clock, qualified by `d_valid`. Back-to-back words stream with no idle gap, so the downstream SISO stage sees a continuous bit stream.

---
 rtl/serial_pkg.sv | 12 +
 rtl/piso_serializer_bit_counter.sv | 25 ++
 rtl/piso_serializer.sv | 67 ++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and word size for the serial datapath
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Word size shared with the downstream SISO stage
    localparam int SERIAL_WIDTH = 8;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// rtl/piso_serializer_bit_counter.sv - modulo-MOD counter with clear/enable and terminal count
module bit_counter #(
    parameter int MOD = 8,
    parameter int CW  = $clog2(MOD)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with back-to-back word streaming
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH      = SERIAL_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             last_bit,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic             in_shift;
    logic             tc;
    logic             handshake;
    logic             head;

    assign in_shift   = (state == ST_SHIFT);
    assign last_bit   = in_shift && tc;
    // Ready only in IDLE or on the final bit, so a new word lands with no gap
    assign load_ready = !in_shift || tc;
    assign handshake  = load_valid && load_ready;

    assign head       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    assign d_out   = in_shift ? head : IDLE_LEVEL;
    assign d_valid = in_shift;
    assign busy    = in_shift;

    // Held at zero in IDLE; wraps to zero on its own at the end of each word
    bit_counter #(
        .MOD (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_shift),
        .enable (in_shift),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
        end else if (handshake) begin
            state <= ST_SHIFT;
            sr    <= load_data;
        end else if (in_shift) begin
            sr <= sr_shifted;
            if (tc) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;

    logic load_ready, d_out, d_valid, last_bit, busy;
    logic load_ready_l, d_out_l, d_valid_l, last_bit_l, busy_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_l),
        .d_out      (d_out_l),
        .d_valid    (d_valid_l),
        .last_bit   (last_bit_l),
        .busy       (busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dv"}, d_valid, 0);
        chk({tag, "_dout"}, d_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, load_ready, 1);
        chk({tag, "_last"}, last_bit, 0);
        chk({tag, "_dv_l"}, d_valid_l, 0);
        chk({tag, "_dout_l"}, d_out_l, 0);
    endtask

    task automatic chk_bit(input string tag, input int k, input logic [7:0] w);
        chk({tag, "_dv"}, d_valid, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_dout"}, d_out, w[7-k]);
        chk({tag, "_last"}, last_bit, (k == 7));
        chk({tag, "_rdy"}, load_ready, (k == 7));
        chk({tag, "_dv_l"}, d_valid_l, 1);
        chk({tag, "_dout_l"}, d_out_l, w[k]);
        chk({tag, "_last_l"}, last_bit_l, (k == 7));
    endtask

    task automatic send_word(input string tag, input logic [7:0] w);
        load_valid = 1'b1;
        load_data  = w;
        chk({tag, "_rdy0"}, load_ready, 1);
        tick();
        load_valid = 1'b0;
        load_data  = ~w;
        for (int k = 0; k < 8; k++) begin
            chk_bit(tag, k, w);
            tick();
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("rst");
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        tick();
        chk_idle("rst_noacc");

        send_word("a5", 8'hA5);
        send_word("01", 8'h01);

        // Back-to-back: F0 then 0F with load_valid held high
        load_valid = 1'b1;
        load_data  = 8'hF0;
        tick();
        load_data  = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) chk_bit("b2b0", k, 8'hF0);
            else       chk_bit("b2b1", k - 8, 8'h0F);
            if (k == 15) load_valid = 1'b0;
            tick();
        end
        chk_idle("b2b_end");

        // Backpressure: 3C presented mid-word, accepted only at the last bit
        load_valid = 1'b1;
        load_data  = 8'hC3;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                load_valid = 1'b1;
                load_data  = 8'h3C;
            end
            chk_bit("bp0", k, 8'hC3);
            tick();
        end
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_bit("bp1", k, 8'h3C);
            tick();
        end
        chk_idle("bp_end");

        // Reset mid-word at bit 4 of AA
        load_valid = 1'b1;
        load_data  = 8'hAA;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_bit("rmw", k, 8'hAA);
            tick();
        end
        chk("rmw_b4", d_out, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rmw_rst");
        send_word("55", 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
